// File: rtl/riscv_ctrl_pkg.sv
// Shared RV32I control definitions: FSM states, opcode classes and mux encodings.
// Used by mc_ctrl, the immediate generator and the datapath.
package riscv_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] PC_PLUS4 = 2'b00;
   localparam logic [1:0] PC_IMM   = 2'b01;
   localparam logic [1:0] PC_ALU   = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   function automatic logic is_legal_op(input logic [6:0] op);
      return (op == OP_LOAD)   || (op == OP_STORE) || (op == OP_BRANCH) ||
             (op == OP_IMM)    || (op == OP_REG)   || (op == OP_JAL)    ||
             (op == OP_JALR);
   endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Instruction/data memory handshake between the control FSM (master) and memories (slave).
interface mc_ctrl_if;
   logic imem_req;
   logic imem_ack;
   logic dmem_req;
   logic dmem_we;
   logic dmem_ack;

   modport master (
      output imem_req, dmem_req, dmem_we,
      input  imem_ack, dmem_ack
   );

   modport slave (
      input  imem_req, dmem_req, dmem_we,
      output imem_ack, dmem_ack
   );
endinterface

// File: rtl/mc_timeout_cnt.sv
// Wait-cycle counter for an outstanding memory request; flags the cycle the wait limit is reached.
// MEM_TIMEOUT = 0 never flags.
module mc_timeout_cnt #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_req,
   input  logic i_ack,
   output logic o_hit
);

   localparam int             CW     = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CW-1:0]  LIMIT  = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
   localparam logic           ENABLE = (MEM_TIMEOUT > 0);

   logic [CW-1:0] r_cnt;
   logic          w_wait;
   logic          w_at_limit;

   assign w_wait     = i_req & ~i_ack;
   assign w_at_limit = (r_cnt == LIMIT);
   // An ack in the limit cycle clears w_wait, so it always beats the trap.
   assign o_hit      = ENABLE & w_wait & w_at_limit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!w_wait) begin
         r_cnt <= '0;
      end else if (!w_at_limit) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with sticky trap on illegal op or timeout.
// Optional MC_CTRL_PERF_EN adds cycle and retired-instruction counters.
module mc_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   mc_ctrl_if.master   mem,
   input  logic [6:0]  i_opcode,
   input  logic        i_br_taken,
   output logic        o_ir_we,
   output logic        o_pc_we,
   output logic [1:0]  o_pc_sel,
   output logic        o_alu_src_imm,
   output logic        o_rf_we,
   output logic [1:0]  o_wb_sel,
   output logic        o_retire,
   output logic        o_trap,
   output logic        o_timeout_err
`ifdef MC_CTRL_PERF_EN
   ,
   output logic [31:0] o_cycle_cnt,
   output logic [31:0] o_instret_cnt
`endif
);

   state_t      r_state;
   state_t      w_next;
   logic        r_timeout_err;

   logic        w_imem_req;
   logic        w_dmem_req;
   logic        w_dmem_we;
   logic        w_ir_we;
   logic        w_pc_we;
   logic [1:0]  w_pc_sel;
   logic        w_alu_src_imm;
   logic        w_rf_we;
   logic [1:0]  w_wb_sel;
   logic        w_retire;
   logic        w_set_toe;

   logic        w_req;
   logic        w_ack;
   logic        w_hit;

   // Only the ack belonging to the current request state is honoured.
   assign w_req = (r_state == ST_FETCH) || (r_state == ST_MEM);
   assign w_ack = (r_state == ST_FETCH) ? mem.imem_ack :
                  (r_state == ST_MEM)   ? mem.dmem_ack : 1'b0;

   mc_timeout_cnt #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
      .clk   (clk),
      .rst_n (rst_n),
      .i_req (w_req),
      .i_ack (w_ack),
      .o_hit (w_hit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_FETCH;
         r_timeout_err <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_set_toe) r_timeout_err <= 1'b1;
      end
   end

   always_comb begin
      w_next        = r_state;
      w_imem_req    = 1'b0;
      w_dmem_req    = 1'b0;
      w_dmem_we     = 1'b0;
      w_ir_we       = 1'b0;
      w_pc_we       = 1'b0;
      w_pc_sel      = PC_PLUS4;
      w_alu_src_imm = 1'b0;
      w_rf_we       = 1'b0;
      w_wb_sel      = WB_ALU;
      w_retire      = 1'b0;
      w_set_toe     = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_imem_req = 1'b1;
            if (w_ack) begin
               w_ir_we = 1'b1;
               w_next  = ST_DECODE;
            end else if (w_hit) begin
               w_set_toe = 1'b1;
               w_next    = ST_TRAP;
            end
         end
         ST_DECODE: begin
            w_next = is_legal_op(i_opcode) ? ST_EXEC : ST_TRAP;
         end
         ST_EXEC: begin
            case (i_opcode)
               OP_IMM, OP_REG: begin
                  w_alu_src_imm = (i_opcode == OP_IMM);
                  w_next        = ST_WB;
               end
               OP_LOAD, OP_STORE: begin
                  w_alu_src_imm = 1'b1;
                  w_next        = ST_MEM;
               end
               OP_BRANCH: begin
                  w_pc_we  = 1'b1;
                  w_pc_sel = i_br_taken ? PC_IMM : PC_PLUS4;
                  w_retire = 1'b1;
                  w_next   = ST_FETCH;
               end
               OP_JAL: begin
                  w_rf_we  = 1'b1;
                  w_wb_sel = WB_PC4;
                  w_pc_we  = 1'b1;
                  w_pc_sel = PC_IMM;
                  w_retire = 1'b1;
                  w_next   = ST_FETCH;
               end
               OP_JALR: begin
                  w_alu_src_imm = 1'b1;
                  w_rf_we       = 1'b1;
                  w_wb_sel      = WB_PC4;
                  w_pc_we       = 1'b1;
                  w_pc_sel      = PC_ALU;
                  w_retire      = 1'b1;
                  w_next        = ST_FETCH;
               end
               default: w_next = ST_TRAP;
            endcase
         end
         ST_MEM: begin
            w_dmem_req = 1'b1;
            w_dmem_we  = (i_opcode == OP_STORE);
            if (w_ack) begin
               if (i_opcode == OP_STORE) begin
                  w_pc_we  = 1'b1;
                  w_retire = 1'b1;
                  w_next   = ST_FETCH;
               end else begin
                  w_next = ST_WB;
               end
            end else if (w_hit) begin
               w_set_toe = 1'b1;
               w_next    = ST_TRAP;
            end
         end
         ST_WB: begin
            w_rf_we  = 1'b1;
            w_wb_sel = (i_opcode == OP_LOAD) ? WB_MEM : WB_ALU;
            w_pc_we  = 1'b1;
            w_retire = 1'b1;
            w_next   = ST_FETCH;
         end
         default: w_next = ST_TRAP;
      endcase
   end

   // Outputs are forced low while rst_n is asserted so requests drop without waiting for a clock.
   assign mem.imem_req  = rst_n & w_imem_req;
   assign mem.dmem_req  = rst_n & w_dmem_req;
   assign mem.dmem_we   = rst_n & w_dmem_we;
   assign o_ir_we       = rst_n & w_ir_we;
   assign o_pc_we       = rst_n & w_pc_we;
   assign o_pc_sel      = rst_n ? w_pc_sel : 2'b00;
   assign o_alu_src_imm = rst_n & w_alu_src_imm;
   assign o_rf_we       = rst_n & w_rf_we;
   assign o_wb_sel      = rst_n ? w_wb_sel : 2'b00;
   assign o_retire      = rst_n & w_retire;
   assign o_trap        = rst_n & (r_state == ST_TRAP);
   assign o_timeout_err = rst_n & r_timeout_err;

`ifdef MC_CTRL_PERF_EN
   logic [31:0] r_cycle_cnt;
   logic [31:0] r_instret_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cycle_cnt   <= '0;
         r_instret_cnt <= '0;
      end else begin
         if (r_state != ST_TRAP) r_cycle_cnt <= r_cycle_cnt + 32'd1;
         if (w_retire)           r_instret_cnt <= r_instret_cnt + 32'd1;
      end
   end

   assign o_cycle_cnt   = r_cycle_cnt;
   assign o_instret_cnt = r_instret_cnt;
`endif

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multicycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback around the shared ALU, register file, immediate generator and memory ports.
- It decodes the opcode classes the immediate generator supports, plus R-type. It drives PC, IR, register file and memory enables, and it traps on illegal opcodes or memory timeouts.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles a memory request may wait for ack; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0]
- br_taken  in  1  branch comparison result from the ALU, valid in EXEC
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid this cycle
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req=1
- dmem_ack  in  1  data access complete this cycle
- ir_we  out  1  latch instruction register
- pc_we  out  1  update PC
- pc_sel  out  2  00 PC+4, 01 PC+imm, 10 ALU result with bit0 cleared (JALR)
- alu_src_imm  out  1  ALU operand B = Imm_out
- rf_we  out  1  register file write
- wb_sel  out  2  00 ALU, 01 memory data, 10 PC+4
- retire  out  1  one-cycle pulse per completed instruction
- trap  out  1  sticky; set on illegal opcode or timeout
- timeout_err  out  1  sticky; trap cause was a memory timeout

Behaviour:
- Reset (rst_n=0, async): state=FETCH, timeout counter=0. All outputs are 0, including trap and timeout_err.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Unlisted outputs are 0 in every state.
- FETCH:
  - imem_req=1 until imem_ack.
  - On the ack cycle: ir_we=1, next state DECODE.
- DECODE: one cycle.
  - Legal opcodes: 0000011, 0100011, 1100011, 0010011, 0110011, 1101111, 1100111. Legal -> EXEC.
  - Any other opcode -> TRAP, trap=1.
- EXEC, by opcode:
  - 0010011 (op-imm): alu_src_imm=1 -> WB.
  - 0110011 (R-type): alu_src_imm=0 -> WB.
  - 0000011 (load) and 0100011 (store): alu_src_imm=1 (address) -> MEM.
  - 1100011 (branch): pc_we=1, pc_sel=01 if br_taken else 00, retire=1 -> FETCH.
  - 1101111 (JAL): rf_we=1, wb_sel=10, pc_we=1, pc_sel=01, retire=1 -> FETCH.
  - 1100111 (JALR): alu_src_imm=1, rf_we=1, wb_sel=10, pc_we=1, pc_sel=10, retire=1 -> FETCH.
- MEM:
  - dmem_req=1 and dmem_we=(opcode==0100011) until dmem_ack.
  - Store on ack: pc_we=1, pc_sel=00, retire=1 -> FETCH.
  - Load on ack -> WB.
- WB:
  - rf_we=1; wb_sel=01 for load, else 00.
  - pc_we=1, pc_sel=00, retire=1 -> FETCH.
- Zero-wait latency (ack in the same cycle as req):
  - ALU ops and stores: 4 cycles.
  - Loads: 5 cycles.
  - Branch, JAL, JALR: 3 cycles.
- Timeout counter:
  - Cleared on entry to FETCH and MEM; increments each cycle the request is high without ack.
  - When the count reaches MEM_TIMEOUT-1 with no ack: TRAP, trap=1, timeout_err=1.
  - An ack in the threshold cycle wins; no trap.
- TRAP: all enables 0, no requests. trap stays 1 until reset.
- Request stability: req and dmem_we never deassert before ack, except on reset.
- Reset mid-request: req drops immediately (async), no retire pulse, restart in FETCH.
- Multi-cycle ack: an ack high longer than one cycle counts only in the request state; a stray ack in other states is ignored.

Optional Feature:
- Macro: MC_CTRL_PERF_EN.
- Defined: adds outputs cycle_cnt[31:0] and instret_cnt[31:0].
  - Both reset to 0 and wrap at 2^32.
  - cycle_cnt increments every cycle while not in TRAP.
  - instret_cnt increments on each retire pulse.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package riscv_ctrl_pkg:
  - state enum (FETCH..TRAP)
  - opcode localparams (OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM, OP_REG, OP_JAL, OP_JALR)
  - pc_sel encodings (PC_PLUS4, PC_IMM, PC_ALU)
  - wb_sel encodings (WB_ALU, WB_MEM, WB_PC4)
- The package is shared with imm_Gen and the datapath.
- One sub-module, mc_timeout_cnt: clear, count and threshold-hit logic, parameterised by MEM_TIMEOUT.

Test Plan:
1. addi x1,x0,5 (0x00500093), ack same cycle -> rf_we pulse in cycle 4 with wb_sel=00 and alu_src_imm=1 in EXEC; one retire.
2. lw (0x0000A083), dmem_ack delayed 3 cycles -> dmem_req=1 and dmem_we=0 held 4 cycles; rf_we with wb_sel=01 after the ack; retire in WB.
3. beq taken (0x00000463), br_taken=1 -> pc_we with pc_sel=01 in EXEC; rf_we never asserted; retire at cycle 3.
4. jalr (0x000080E7) -> rf_we=1, wb_sel=10, pc_sel=10 in the same EXEC cycle.
5. Illegal opcode 0x0000007F -> trap=1 after DECODE, timeout_err=0; no further imem_req until rst_n pulse.
6. MEM_TIMEOUT=4, imem_ack held 0 -> trap and timeout_err set after 4 request cycles. Repeat with ack on cycle 4: no trap. Assert rst_n=0 mid-MEM: all outputs 0 immediately.
